// File: rtl/remap_pkg.sv
// Shared types and widths for the remap frame scheduler and its tag FIFO.
package remap_pkg;

  localparam int unsigned FRAC    = 12;
  localparam int unsigned COORD_W = 24;
  localparam int unsigned IDX_W   = 19;
  localparam int unsigned PIX_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             border;
  } tag_t;

endpackage

// File: rtl/remap_tag_fifo.sv
// Show-ahead tag FIFO tracking issued pixels until they are written back in order.
module remap_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  // A push while full is legal only when the head is leaving in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/remap_frame_sched.sv
// Frame scheduler: walks destination pixels in raster order, issues map coordinates to remap,
// substitutes a border value for out-of-range coordinates and writes results back in order.
module remap_frame_sched
  import remap_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480,
  parameter int unsigned FRAC         = remap_pkg::FRAC,
  parameter int unsigned MAX_OUTSTAND = 4,
  parameter logic [7:0]  BORDER_VAL   = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err_spurious,
  output logic [IDX_W-1:0]     border_cnt,
  output logic                 lut_rd_en,
  output logic [IDX_W-1:0]     lut_rd_addr,
  input  logic [2*COORD_W-1:0] lut_rd_data,
  output logic                 map_valid,
  output logic [COORD_W-1:0]   map_x,
  output logic [COORD_W-1:0]   map_y,
  input  logic                 map_ready,
  input  logic                 out_valid,
  input  logic [PIX_W-1:0]     out_pixel,
  output logic                 dst_wr_en,
  output logic [IDX_W-1:0]     dst_wr_addr,
  output logic [PIX_W-1:0]     dst_wr_data
);

  localparam int unsigned        NPIX     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'((IMAGE_WIDTH - 1) << FRAC);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'((IMAGE_HEIGHT - 1) << FRAC);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [COORD_W-1:0]   mx_q, mx_d, my_q, my_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 aborted_q, aborted_d, err_q, err_d;
  logic [IDX_W-1:0]     border_cnt_q, border_cnt_d;

  logic                 push, pop, advance, spurious, is_border, fifo_room;
  logic                 fifo_full, fifo_empty;
  tag_t                 push_tag, head_tag;
  logic [$bits(tag_t)-1:0] head_raw;

  assign is_border = mx_q[COORD_W-1] | my_q[COORD_W-1] | (mx_q > X_MAX) | (my_q > Y_MAX);
  assign push_tag  = '{idx: idx_q, border: is_border};
  assign head_tag  = tag_t'(head_raw);

  // Retirement runs every cycle regardless of the FSM; border heads need no remap result.
  assign pop       = !fifo_empty && (head_tag.border || out_valid);
  assign spurious  = out_valid && (fifo_empty || head_tag.border);
  assign fifo_room = !fifo_full || pop;

  assign dst_wr_en   = pop;
  assign dst_wr_addr = pop ? head_tag.idx : '0;
  assign dst_wr_data = !pop ? '0 : (head_tag.border ? BORDER_VAL : out_pixel);

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign err_spurious = err_q;
  assign border_cnt   = border_cnt_q;
  assign lut_rd_addr  = idx_q;
  assign map_x        = mx_q;
  assign map_y        = my_q;

  remap_tag_fifo #(
    .DEPTH (MAX_OUTSTAND),
    .WIDTH ($bits(tag_t))
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_tag),
    .pop_i   (pop),
    .head_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mx_d         = mx_q;
    my_d         = my_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    err_d        = err_q | spurious;
    border_cnt_d = border_cnt_q;
    lut_rd_en    = 1'b0;
    map_valid    = 1'b0;
    push         = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d      = FETCH;
          busy_d       = 1'b1;
          idx_d        = '0;
          aborted_d    = 1'b0;
          err_d        = spurious;
          border_cnt_d = '0;
        end
      end
      FETCH: begin
        lut_rd_en = 1'b1;
        if (abort) begin
          state_d   = DRAIN;
          aborted_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d   = DRAIN;
          aborted_d = 1'b1;
        end else begin
          mx_d    = lut_rd_data[COORD_W-1:0];
          my_d    = lut_rd_data[2*COORD_W-1:COORD_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // An abort cycle issues nothing, so no request can slip out untracked.
        if (abort) begin
          state_d   = DRAIN;
          aborted_d = 1'b1;
        end else if (fifo_room) begin
          if (is_border) begin
            push         = 1'b1;
            border_cnt_d = border_cnt_q + IDX_W'(1);
            advance      = 1'b1;
          end else begin
            map_valid = 1'b1;
            if (map_ready) begin
              push    = 1'b1;
              advance = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DRAIN;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mx_q         <= '0;
      my_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_q        <= 1'b0;
      border_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mx_q         <= mx_d;
      my_q         <= my_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      err_q        <= err_d;
      border_cnt_q <= border_cnt_d;
    end
  end

endmodule

// File: tb/tb_remap_frame_sched.sv
// Directed bench for remap_frame_sched on a 4x2 frame with a latency-configurable remap model.
module tb_remap_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, aborted, err_spurious;
  logic [18:0] border_cnt;
  logic        lut_rd_en;
  logic [18:0] lut_rd_addr;
  logic [47:0] lut_rd_data = '0;
  logic        map_valid;
  logic [23:0] map_x, map_y;
  logic        map_ready = 1'b1;
  logic        out_valid = 1'b0;
  logic [7:0]  out_pixel = '0;
  logic        dst_wr_en;
  logic [18:0] dst_wr_addr;
  logic [7:0]  dst_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  remap_frame_sched #(
    .IMAGE_WIDTH  (4),
    .IMAGE_HEIGHT (2),
    .FRAC         (12),
    .MAX_OUTSTAND (4),
    .BORDER_VAL   (8'd0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .err_spurious (err_spurious),
    .border_cnt   (border_cnt),
    .lut_rd_en    (lut_rd_en),
    .lut_rd_addr  (lut_rd_addr),
    .lut_rd_data  (lut_rd_data),
    .map_valid    (map_valid),
    .map_x        (map_x),
    .map_y        (map_y),
    .map_ready    (map_ready),
    .out_valid    (out_valid),
    .out_pixel    (out_pixel),
    .dst_wr_en    (dst_wr_en),
    .dst_wr_addr  (dst_wr_addr),
    .dst_wr_data  (dst_wr_data)
  );

  // ---------------- LUT / remap model and monitor ----------------
  logic [23:0] lut_x [8];
  logic [23:0] lut_y [8];
  int          lat = 3;
  int          cyc = 0;
  int          pend_due [$];
  logic [7:0]  pend_pix [$];
  int          wr_addr [$];
  int          wr_data [$];
  int          hs_cnt = 0, hs_idx3 = 0, done_cnt = 0, max_pend = 0;
  int          unstable_cnt = 0, stall_cycles = 0;
  logic [18:0] lut_addr_s = '0;
  logic        mv_s = 1'b0;
  bit          hold_en = 0;
  int          hold_idx = 0, hold_len = 0, hold_cnt = 0;
  bit          inject_ov = 0;
  logic        prev_wait = 1'b0;
  logic [23:0] prev_x = '0, prev_y = '0;

  // Inputs change on the falling edge; outputs are sampled 1 time unit before the rising edge.
  always begin
    int px;
    @(negedge clk);
    lut_rd_data = {lut_y[lut_addr_s[2:0]], lut_x[lut_addr_s[2:0]]};
    out_valid = 1'b0;
    out_pixel = '0;
    if (inject_ov) begin
      out_valid = 1'b1;
      out_pixel = 8'hA5;
      inject_ov = 0;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      out_valid = 1'b1;
      out_pixel = pend_pix.pop_front();
      void'(pend_due.pop_front());
    end
    if (hold_en && lut_addr_s == 19'(hold_idx) && hold_cnt < hold_len) begin
      map_ready = 1'b0;
      hold_cnt++;
    end else begin
      map_ready = 1'b1;
    end
    #4;
    cyc++;
    if (lut_rd_en) lut_addr_s = lut_rd_addr;
    mv_s = map_valid;
    if (map_valid && !map_ready) begin
      stall_cycles++;
      if (prev_wait && (map_x !== prev_x || map_y !== prev_y)) unstable_cnt++;
    end
    prev_wait = map_valid && !map_ready;
    prev_x = map_x;
    prev_y = map_y;
    if (map_valid && map_ready) begin
      hs_cnt++;
      if (map_x == 24'h003000 && map_y == 24'h0) hs_idx3++;
      px = ((int'(map_y) >> 12) * 4 + (int'(map_x) >> 12)) * 10;
      pend_pix.push_back(8'(px));
      pend_due.push_back(cyc + lat);
    end
    if (pend_due.size() > max_pend) max_pend = pend_due.size();
    if (dst_wr_en) begin
      wr_addr.push_back(int'(dst_wr_addr));
      wr_data.push_back(int'(dst_wr_data));
    end
    if (done) done_cnt++;
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic init_lut();
    for (int i = 0; i < 8; i++) begin
      lut_x[i] = 24'((i % 4) << 12);
      lut_y[i] = 24'((i / 4) << 12);
    end
  endtask

  task automatic run_start();
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    hs_cnt = 0; hs_idx3 = 0; max_pend = 0; unstable_cnt = 0; stall_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > d0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [119:0] obs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {busy, done, aborted, err_spurious, lut_rd_en, map_valid, dst_wr_en, border_cnt,
           lut_rd_addr, map_x, map_y, dst_wr_addr, dst_wr_data};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", obs);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, lut_rd_en, map_valid, dst_wr_en} !== 5'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b required 00000",
                         {busy, done, lut_rd_en, map_valid, dst_wr_en});
    end
  endtask

  task automatic test_identity();
    bit ok;
    lat = 3;
    init_lut();
    run_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL id_busy: got %b required 1", busy); end
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL id_done: got timeout required done"); end
    n_checks++;
    if (wr_addr.size() != 8) begin n_fail++; $display("FAIL id_count: got %0d required 8", wr_addr.size()); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i || wr_data[i] != i * 10) begin
        n_fail++; $display("FAIL id_write%0d: got %0d/%0d required %0d/%0d", i, wr_addr[i], wr_data[i], i, i * 10);
      end
    end
    n_checks++;
    if ({busy, aborted, border_cnt} !== 21'b0) begin
      n_fail++; $display("FAIL id_status: got busy=%b aborted=%b border=%0d required 0/0/0", busy, aborted, border_cnt);
    end
    n_checks++;
    if (hs_cnt != 8) begin n_fail++; $display("FAIL id_transfers: got %0d required 8", hs_cnt); end
  endtask

  task automatic test_border();
    bit ok;
    int exp_d [8] = '{0, 10, 0, 30, 40, 0, 60, 70};
    lat = 3;
    init_lut();
    lut_x[2] = 24'h800000;
    lut_y[5] = 24'h002000;
    run_start();
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bd_done: got timeout required done"); end
    n_checks++;
    if (wr_addr.size() != 8) begin n_fail++; $display("FAIL bd_count: got %0d required 8", wr_addr.size()); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i || wr_data[i] != exp_d[i]) begin
        n_fail++; $display("FAIL bd_write%0d: got %0d/%0d required %0d/%0d", i, wr_addr[i], wr_data[i], i, exp_d[i]);
      end
    end
    n_checks++;
    if (border_cnt !== 19'd2) begin n_fail++; $display("FAIL bd_border_cnt: got %0d required 2", border_cnt); end
    n_checks++;
    if (hs_cnt != 6) begin n_fail++; $display("FAIL bd_transfers: got %0d required 6", hs_cnt); end
    init_lut();
  endtask

  task automatic test_ready_stall();
    bit ok;
    lat = 3;
    init_lut();
    hold_idx = 3; hold_len = 10; hold_cnt = 0; hold_en = 1;
    run_start();
    wait_done(300, ok);
    hold_en = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL st_done: got timeout required done"); end
    n_checks++;
    if (stall_cycles != 9) begin n_fail++; $display("FAIL st_stall_cycles: got %0d required 9", stall_cycles); end
    n_checks++;
    if (unstable_cnt != 0) begin n_fail++; $display("FAIL st_stable: got %0d changes required 0", unstable_cnt); end
    n_checks++;
    if (hs_idx3 != 1 || hs_cnt != 8) begin
      n_fail++; $display("FAIL st_transfers: got idx3=%0d total=%0d required 1/8", hs_idx3, hs_cnt);
    end
    n_checks++;
    if (wr_addr.size() != 8) begin n_fail++; $display("FAIL st_count: got %0d required 8", wr_addr.size()); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i || wr_data[i] != i * 10) begin
        n_fail++; $display("FAIL st_write%0d: got %0d/%0d required %0d/%0d", i, wr_addr[i], wr_data[i], i, i * 10);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    lat = 40;
    init_lut();
    run_start();
    wait_done(800, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bb_done: got timeout required done"); end
    n_checks++;
    if (max_pend != 4) begin n_fail++; $display("FAIL bb_outstanding: got %0d required 4", max_pend); end
    n_checks++;
    if (wr_addr.size() != 8) begin n_fail++; $display("FAIL bb_count: got %0d required 8", wr_addr.size()); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i || wr_data[i] != i * 10) begin
        n_fail++; $display("FAIL bb_write%0d: got %0d/%0d required %0d/%0d", i, wr_addr[i], wr_data[i], i, i * 10);
      end
    end
    lat = 3;
  endtask

  task automatic test_abort();
    bit ok;
    bit got2;
    lat = 10;
    init_lut();
    hold_idx = 4; hold_len = 1000; hold_cnt = 0; hold_en = 1;
    run_start();
    got2 = 0;
    for (int i = 0; i < 200; i++) begin
      if (wr_addr.size() >= 2) begin got2 = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!got2) begin n_fail++; $display("FAIL ab_reach: got timeout required 2 writes"); end
    n_checks++;
    if (pend_due.size() != 2 || mv_s !== 1'b1) begin
      n_fail++; $display("FAIL ab_precond: got pending=%0d map_valid=%b required 2/1", pend_due.size(), mv_s);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(200, ok);
    hold_en = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ab_done: got timeout required done"); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (aborted !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ab_status: got aborted=%b busy=%b required 1/0", aborted, busy);
    end
    n_checks++;
    if (wr_addr.size() != 4 || hs_cnt != 4) begin
      n_fail++; $display("FAIL ab_count: got writes=%0d transfers=%0d required 4/4", wr_addr.size(), hs_cnt);
    end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i || wr_data[i] != i * 10) begin
        n_fail++; $display("FAIL ab_write%0d: got %0d/%0d required %0d/%0d", i, wr_addr[i], wr_data[i], i, i * 10);
      end
    end
    lat = 3;
  endtask

  task automatic test_spurious_and_restart();
    bit ok;
    int d0;
    lat = 3;
    init_lut();
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    @(posedge clk);
    inject_ov = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL sp_err: got %b required 1", err_spurious); end
    n_checks++;
    if (wr_addr.size() != 0) begin n_fail++; $display("FAIL sp_nowrite: got %0d writes required 0", wr_addr.size()); end
    d0 = done_cnt;
    run_start();
    n_checks++;
    if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL sp_err_clear: got %b required 0", err_spurious); end
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300, ok);
    repeat (30) @(negedge clk);
    n_checks++;
    if (!ok || done_cnt != d0 + 1) begin
      n_fail++; $display("FAIL rs_done_once: got %0d done pulses required 1", done_cnt - d0);
    end
    n_checks++;
    if (wr_addr.size() != 8 || hs_cnt != 8) begin
      n_fail++; $display("FAIL rs_count: got writes=%0d transfers=%0d required 8/8", wr_addr.size(), hs_cnt);
    end
    n_checks++;
    if (wr_addr.size() == 8 && (wr_addr[7] != 7 || wr_data[7] != 70)) begin
      n_fail++; $display("FAIL rs_last: got %0d/%0d required 7/70", wr_addr[7], wr_data[7]);
    end
  endtask

  task automatic test_reset_midframe();
    bit got;
    int d0, wsz;
    logic [119:0] obs;
    lat = 3;
    init_lut();
    run_start();
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (wr_addr.size() >= 2) begin got = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!got || busy !== 1'b1) begin n_fail++; $display("FAIL rm_reach: got busy=%b required mid-frame", busy); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    obs = {busy, done, aborted, err_spurious, lut_rd_en, map_valid, dst_wr_en, border_cnt,
           lut_rd_addr, map_x, map_y, dst_wr_addr, dst_wr_data};
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL rm_outputs: got %h required 0", obs); end
    pend_due.delete();
    pend_pix.delete();
    d0 = done_cnt;
    wsz = wr_addr.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0 || wr_addr.size() != wsz) begin
      n_fail++; $display("FAIL rm_killed: got done=%0d busy=%b writes=%0d required 0/0/none",
                         done_cnt - d0, busy, wr_addr.size() - wsz);
    end
  endtask

  initial begin
    init_lut();
    test_reset();
    test_identity();
    test_border();
    test_ready_stall();
    test_back_to_back();
    test_abort();
    test_spurious_and_restart();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
